// File: rtl/nrd_div_16b_if.sv
// Request/response bundle for the 16-bit non-restoring divider.
// The master issues start with the operands; the slave returns busy, out_valid, the results and the flags.
interface nrd_div_16b_if;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        out_valid;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;
    logic        ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, out_valid, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, out_valid, quotient, remainder, div_zero, ovf
    );
endinterface

// File: rtl/nrd_div_16b.sv
// Radix-2 non-restoring divider built around one 16-bit CLA. Latency is a fixed 17 cycles from accept to out_valid.
// One operation is in flight at a time, and start is ignored while busy, with no queuing.
module cla_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g, p;
    logic [16:0] c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gc = '0;
        c  = '0;
        gc[0] = cin;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int i = 0; i < 16; i++) begin
            c[i+1] = ((i % 4) == 3) ? gc[i/4 + 1] : (g[i] | (p[i] & ((i % 4) == 0 ? gc[i/4] : c[i])));
        end
        sum  = p ^ {c[15:1], gc[0]};
        cout = gc[4];
    end
endmodule

module nrd_div_16b #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    nrd_div_16b_if.slave dv
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nxt;

    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q, d, dvd;
    logic [3:0]       cnt;
    logic             neg_q, neg_r, dz, of;
    logic [WIDTH-1:0] quo_q, rem_q;
    logic             vld_q, dz_q, ovf_q;

    logic [WIDTH:0]   r_sh, add_sum, r_fix;
    logic [WIDTH-1:0] add_a, add_b, add_s, q_fin, r_fin, dvd_mag, dsr_mag;
    logic             sub, add_co;

    cla_16b u_cla (.a(add_a), .b(add_b), .cin(sub), .sum(add_s), .cout(add_co));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            r     <= '0;
            q     <= '0;
            d     <= '0;
            dvd   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            of    <= 1'b0;
            quo_q <= '0;
            rem_q <= '0;
            vld_q <= 1'b0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            vld_q <= 1'b0;
            case (state)
                IDLE: if (dv.start) begin
                    r     <= '0;
                    q     <= dvd_mag;
                    d     <= dsr_mag;
                    dvd   <= dv.dividend;
                    cnt   <= '0;
                    neg_q <= SIGNED && (dv.dividend[WIDTH-1] ^ dv.divisor[WIDTH-1]);
                    neg_r <= SIGNED && dv.dividend[WIDTH-1];
                    dz    <= (dv.divisor == '0);
                    of    <= SIGNED && (dv.dividend == 16'h8000) && (dv.divisor == 16'hFFFF);
                end
                CALC: begin
                    r   <= add_sum;
                    q   <= {q[WIDTH-2:0], ~add_sum[WIDTH]};
                    cnt <= cnt + 4'd1;
                end
                FIX: begin
                    vld_q <= 1'b1;
                    dz_q  <= dz;
                    ovf_q <= of;
                    if (dz) begin
                        quo_q <= 16'hFFFF;
                        rem_q <= dvd;
                    end else if (of) begin
                        quo_q <= 16'h8000;
                        rem_q <= '0;
                    end else begin
                        quo_q <= q_fin;
                        rem_q <= r_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dv.start) state_nxt = CALC;
            CALC:    if (cnt == 4'd15) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The CLA does the per-iteration add/subtract in CALC and the final restore add in FIX.
    // The 17th bit of the partial remainder is completed here from the CLA carry-out.
    always_comb begin
        r_sh    = {r[WIDTH-1:0], q[WIDTH-1]};
        sub     = (state == CALC) && !r[WIDTH];
        add_a   = (state == CALC) ? r_sh[WIDTH-1:0] : r[WIDTH-1:0];
        add_b   = sub ? ~d : d;
        add_sum = {((state == CALC) ? r_sh[WIDTH] : r[WIDTH]) ^ sub ^ add_co, add_s};
        r_fix   = r[WIDTH] ? add_sum : r;
        q_fin   = neg_q ? -q : q;
        r_fin   = neg_r ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
        dvd_mag = (SIGNED && dv.dividend[WIDTH-1]) ? -dv.dividend : dv.dividend;
        dsr_mag = (SIGNED && dv.divisor[WIDTH-1])  ? -dv.divisor  : dv.divisor;
    end

    assign dv.busy      = (state != IDLE) || vld_q;
    assign dv.out_valid = vld_q;
    assign dv.quotient  = quo_q;
    assign dv.remainder = rem_q;
    assign dv.div_zero  = dz_q;
    assign dv.ovf       = ovf_q;
endmodule

// File: tb/tb_nrd_div_16b.sv
// Directed checks of the signed and unsigned divider against hand-computed results and the fixed 17-cycle latency.
module tb_nrd_div_16b;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nrd_div_16b_if s_if ();
    nrd_div_16b_if u_if ();

    nrd_div_16b #(.WIDTH(16), .SIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .dv(s_if));
    nrd_div_16b #(.WIDTH(16), .SIGNED(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .dv(u_if));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit uns, input bit st, input logic [15:0] a, input logic [15:0] b);
        if (uns) begin
            u_if.start = st; u_if.dividend = a; u_if.divisor = b;
        end else begin
            s_if.start = st; s_if.dividend = a; s_if.divisor = b;
        end
    endtask

    // Called #1 after an edge; the start raised here is taken at the next edge.
    task automatic run_op(input bit uns, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er,
                          input bit edz, input bit eovf, input bit poke, input string tag);
        int n = 0;
        bit ov = 1'b0;
        drive(uns, 1'b1, a, b);
        @(posedge clk); #1;
        drive(uns, 1'b0, a, b);
        while (!ov && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check({tag, ".busy1"}, uns ? u_if.busy : s_if.busy, 1);
            if (poke && n == 4) drive(uns, 1'b1, 16'h1234, 16'h0003);
            if (poke && n == 5) drive(uns, 1'b0, a, b);
            ov = uns ? u_if.out_valid : s_if.out_valid;
        end
        check({tag, ".lat"}, n, 17);
        check({tag, ".q"}, uns ? u_if.quotient : s_if.quotient, eq);
        check({tag, ".r"}, uns ? u_if.remainder : s_if.remainder, er);
        check({tag, ".dz"}, uns ? u_if.div_zero : s_if.div_zero, edz);
        check({tag, ".ovf"}, uns ? u_if.ovf : s_if.ovf, eovf);
        check({tag, ".busyv"}, uns ? u_if.busy : s_if.busy, 1);
    endtask

    initial begin
        int nv;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.q", s_if.quotient, 0);
        check("rst.r", s_if.remainder, 0);
        check("rst.vld", s_if.out_valid, 0);
        check("rst.busy", s_if.busy, 0);
        check("rst.flags", {s_if.div_zero, s_if.ovf}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, 16'd7865, 16'd130, 16'd60, 16'd65, 1'b0, 1'b0, 1'b0, "a");
        @(posedge clk); #1;
        check("a.vld_drop", s_if.out_valid, 0);
        check("a.hold_q", s_if.quotient, 16'd60);
        check("a.idle_busy", s_if.busy, 0);

        run_op(1'b0, 16'hFE1D, 16'd159, 16'hFFFD, 16'hFFFA, 1'b0, 1'b0, 1'b0, "b2b1");
        run_op(1'b0, 16'hFE1D, 16'hFD0C, 16'd0, 16'hFE1D, 1'b0, 1'b0, 1'b0, "b2b2");
        run_op(1'b0, 16'd32767, 16'd1, 16'd32767, 16'd0, 1'b0, 1'b0, 1'b1, "max_poke");
        run_op(1'b0, 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 1'b1, 1'b0, "ovf");
        run_op(1'b0, 16'd100, 16'd0, 16'hFFFF, 16'd100, 1'b1, 1'b0, 1'b0, "dz");
        run_op(1'b0, 16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, 1'b0, 1'b0, "neg_div");

        // Abort an operation with reset at accept+8.
        drive(1'b0, 1'b1, 16'd1000, 16'd7);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'd1000, 16'd7);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort.q", s_if.quotient, 0);
        check("abort.r", s_if.remainder, 0);
        check("abort.busy", s_if.busy, 0);
        check("abort.vld", s_if.out_valid, 0);
        rst_n = 1'b1;
        nv = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (s_if.out_valid) nv++;
        end
        check("abort.no_vld", nv, 0);
        run_op(1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 1'b0, "after_rst");

        run_op(1'b1, 16'd65535, 16'd16, 16'd4095, 16'd15, 1'b0, 1'b0, 1'b0, "u1");
        run_op(1'b1, 16'd40000, 16'd300, 16'd133, 16'd100, 1'b0, 1'b0, 1'b0, "u2");
        run_op(1'b1, 16'h8000, 16'hFFFF, 16'd0, 16'h8000, 1'b0, 1'b0, 1'b0, "u_noovf");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
